// File: rtl/debounce_bank.sv
// Multi-channel debouncer: per-channel synchroniser, consecutive-mismatch counter,
// registered filtered level and one-cycle rise/fall strobes.
module debounce_bank #(
  parameter int       CHANNELS      = 4,
  parameter int       STABLE_CYCLES = 20000,
  parameter int       SYNC_STAGES   = 2,
  parameter logic     RESET_LEVEL   = 1'b0,
  parameter int       CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_data,
  output logic [CHANNELS-1:0] filtered_data,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
  logic [CNT_W-1:0]    cnt_q  [CHANNELS];
  logic [CNT_W-1:0]    cnt_d  [CHANNELS];
  logic [CHANNELS-1:0] filtered_q, filtered_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [CHANNELS-1:0] sync_last;

  always_comb begin
    sync_d[0] = raw_data;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  // A single matching cycle clears the count; the level only moves on the
  // STABLE_CYCLES-th consecutive mismatch, so cnt never wraps.
  always_comb begin
    filtered_d = filtered_q;
    rise_d     = '0;
    fall_d     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_d[c] = '0;
      if (sync_last[c] != filtered_q[c]) begin
        if (cnt_q[c] == CNT_LAST) begin
          filtered_d[c] = sync_last[c];
          rise_d[c]     = sync_last[c];
          fall_d[c]     = ~sync_last[c];
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= {CHANNELS{RESET_LEVEL}};
      end
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= '0;
      end
      filtered_q <= {CHANNELS{RESET_LEVEL}};
      rise_q     <= '0;
      fall_q     <= '0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      filtered_q <= filtered_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      busy[c] = (cnt_q[c] != '0);
    end
  end

  assign filtered_data = filtered_q;
  assign rise          = rise_q;
  assign fall          = fall_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: expected strobe events are queued by the
// stimulus and matched by a monitor whenever a rise/fall strobe appears.
module tb_debounce_bank;

  localparam int CH = 4;
  localparam int SC = 4;
  localparam int SS = 2;
  localparam int LAT = SS + SC;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [CH-1:0] raw_data = '0;
  logic [CH-1:0] filtered_data, rise, fall, busy;

  debounce_bank #(
    .CHANNELS(CH), .STABLE_CYCLES(SC), .SYNC_STAGES(SS), .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .raw_data(raw_data),
    .filtered_data(filtered_data), .rise(rise), .fall(fall), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] filt;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic expect_strobe(input string name, input int at,
                               input logic [CH-1:0] r, input logic [CH-1:0] f,
                               input logic [CH-1:0] filt);
    exp_t e;
    e.cyc = at; e.rise = r; e.fall = f; e.filt = filt; e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    if (mon_en && ((rise | fall) != '0)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {rise, fall}, '0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_cycle"}, cyc, e.cyc);
        chk({e.name, "_rise"}, rise, e.rise);
        chk({e.name, "_fall"}, fall, e.fall);
        chk({e.name, "_filt"}, filtered_data, e.filt);
      end
    end
  end

  initial begin
    int  c0;
    bit  seen_busy;

    // Reset asserted mid-clock with all raw inputs high
    raw_data = 4'b1111;
    #2 reset = 1'b1;
    #1;
    chk("reset_imm_filt", filtered_data, 4'b0000);
    chk("reset_imm_rise", rise, 4'b0000);
    chk("reset_imm_fall", fall, 4'b0000);
    chk("reset_imm_busy", busy, 4'b0000);
    repeat (3) @(negedge clk);
    chk("reset_hold_filt", filtered_data, 4'b0000);
    chk("reset_hold_strb", {rise, fall}, 8'h00);
    chk("reset_hold_busy", busy, 4'b0000);
    raw_data = 4'b0000;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_filt", filtered_data, 4'b0000);
    chk("idle_busy", busy, 4'b0000);

    // Clean press on channel 0
    c0 = cyc;
    raw_data[0] = 1'b1;
    expect_strobe("press0", c0 + LAT, 4'b0001, 4'b0000, 4'b0001);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("press0_busy_k%0d", k), busy[0], (k >= 3 && k <= 5) ? 1'b1 : 1'b0);
      chk($sformatf("press0_filt_k%0d", k), filtered_data, (k >= 6) ? 4'b0001 : 4'b0000);
    end
    chk("press0_others_busy", busy[3:1], 3'b000);

    // Bounce on channel 1: runs of three highs never reach four
    seen_busy = 1'b0;
    for (int r = 0; r < 10; r++) begin
      for (int p = 0; p < 4; p++) begin
        raw_data[1] = (p < 3);
        @(negedge clk);
        seen_busy |= busy[1];
        if (filtered_data[1] !== 1'b0)
          chk("bounce_filt1", filtered_data[1], 1'b0);
      end
    end
    chk("bounce_filt1_end", filtered_data[1], 1'b0);
    chk("bounce_busy_pulsed", seen_busy, 1'b1);
    c0 = cyc;
    raw_data[1] = 1'b1;
    expect_strobe("hold1", c0 + LAT, 4'b0010, 4'b0000, 4'b0011);
    repeat (LAT - 1) @(negedge clk);
    chk("hold1_not_early", filtered_data[1], 1'b0);
    repeat (3) @(negedge clk);
    chk("hold1_filt", filtered_data, 4'b0011);

    // Release on channel 0
    c0 = cyc;
    raw_data[0] = 1'b0;
    expect_strobe("release0", c0 + LAT, 4'b0000, 4'b0001, 4'b0010);
    repeat (LAT + 2) @(negedge clk);
    chk("release0_filt", filtered_data, 4'b0010);

    // Channel 2 up, then channel 2 down and channel 3 up on the same edge
    c0 = cyc;
    raw_data[2] = 1'b1;
    expect_strobe("press2", c0 + LAT, 4'b0100, 4'b0000, 4'b0110);
    repeat (LAT + 2) @(negedge clk);
    c0 = cyc;
    raw_data[2] = 1'b0;
    raw_data[3] = 1'b1;
    expect_strobe("simul", c0 + LAT, 4'b1000, 4'b0100, 4'b1010);
    repeat (LAT + 2) @(negedge clk);
    chk("simul_filt", filtered_data, 4'b1010);

    // Reset in the middle of a count on channel 0
    raw_data[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_busy_before", busy[0], 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_filt", filtered_data, 4'b0000);
    chk("midrst_busy", busy, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    c0 = cyc;
    expect_strobe("after_rst", c0 + LAT, 4'b1011, 4'b0000, 4'b1011);
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      chk($sformatf("after_rst_filt_k%0d", k), filtered_data, 4'b0000);
    end
    repeat (4) @(negedge clk);
    chk("after_rst_final", filtered_data, 4'b1011);

    chk("pending_strobes", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
